// File: rtl/multi_led_pattern_blinker.sv
`default_nettype none
// ============================================================================
// Module  : multi_led_pattern_blinker
// Brief   : NUM_CH LED channels (off/on/blink/burst) on one shared tick prescaler.
// Revision: 1.0
// ============================================================================
module multi_led_pattern_blinker #(
  parameter int CLK_FREQ  = 27_000_000,
  parameter int TICK_FREQ = 1_000,
  parameter int NUM_CH    = 4,
  parameter int PERIOD_W  = 12,
  parameter int BURST_W   = 3,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [PERIOD_W-1:0] cfg_half_period,
  input  logic [BURST_W-1:0]  cfg_count,
  output logic                cfg_err,
  output logic                base_tick,
  output logic [NUM_CH-1:0]   led
);

  localparam int DIV   = CLK_FREQ / TICK_FREQ;
  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int PH_W  = PERIOD_W + 2;

  localparam logic [CNT_W-1:0] C_DIV_LAST = CNT_W'(DIV - 1);
  localparam logic [CH_W:0]    C_NUM_CH   = (CH_W + 1)'(NUM_CH);

  typedef enum logic [1:0] {MODE_OFF, MODE_ON, MODE_BLINK, MODE_BURST} mode_e;
  typedef enum logic [1:0] {B_ON, B_OFF, B_GAP} bstate_e;

  if (DIV < 2) begin : g_div_check
    $error("multi_led_pattern_blinker: CLK_FREQ/TICK_FREQ must be >= 2");
  end
  if (NUM_CH < 1 || NUM_CH > 16) begin : g_ch_check
    $error("multi_led_pattern_blinker: NUM_CH must be 1..16");
  end

  logic [CNT_W-1:0] presc_q, presc_d;
  logic             base_tick_q, base_tick_d;
  logic             cfg_ready_q, cfg_ready_d;
  logic             cfg_err_q, cfg_err_d;
  logic             wr_en;

  always_comb begin
    wr_en       = cfg_valid && cfg_ready_q;
    presc_d     = (presc_q == C_DIV_LAST) ? '0 : presc_q + 1'b1;
    base_tick_d = (presc_q == C_DIV_LAST);
    cfg_ready_d = 1'b1;
    cfg_err_d   = wr_en && ({1'b0, cfg_ch} >= C_NUM_CH);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      presc_q     <= '0;
      base_tick_q <= 1'b0;
      cfg_ready_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      base_tick_q <= base_tick_d;
      cfg_ready_q <= cfg_ready_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign base_tick = base_tick_q;
  assign cfg_ready = cfg_ready_q;
  assign cfg_err   = cfg_err_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    mode_e               mode_q, mode_d;
    bstate_e             bst_q, bst_d;
    logic [PERIOD_W-1:0] half_q, half_d;
    logic [BURST_W-1:0]  num_q, num_d;
    logic [PH_W-1:0]     phase_q, phase_d;
    logic [BURST_W-1:0]  pulse_q, pulse_d;
    logic                led_q, led_d;
    logic                sel, ph_end, gap_end, burst_done;
    logic [BURST_W:0]    pulse_inc;

    always_comb begin
      mode_d     = mode_q;
      bst_d      = bst_q;
      half_d     = half_q;
      num_d      = num_q;
      phase_d    = phase_q;
      pulse_d    = pulse_q;
      led_d      = led_q;
      sel        = wr_en && (cfg_ch == CH_W'(i));
      ph_end     = (phase_q == {2'b00, half_q} - 1'b1);
      gap_end    = (phase_q == {half_q, 2'b00} - 1'b1);
      pulse_inc  = {1'b0, pulse_q} + 1'b1;
      burst_done = (pulse_inc == {1'b0, num_q});

      // A write on this channel takes precedence over a coincident tick.
      if (sel) begin
        mode_d  = mode_e'(cfg_mode);
        half_d  = (cfg_half_period == '0) ? PERIOD_W'(1) : cfg_half_period;
        num_d   = (cfg_count == '0) ? BURST_W'(1) : cfg_count;
        phase_d = '0;
        pulse_d = '0;
        bst_d   = B_ON;
        led_d   = (mode_e'(cfg_mode) != MODE_OFF);
      end else if (base_tick_q) begin
        case (mode_q)
          MODE_BLINK: begin
            if (ph_end) begin
              led_d   = ~led_q;
              phase_d = '0;
            end else begin
              phase_d = phase_q + 1'b1;
            end
          end
          MODE_BURST: begin
            case (bst_q)
              B_ON: begin
                if (ph_end) begin
                  phase_d = '0;
                  pulse_d = pulse_inc[BURST_W-1:0];
                  led_d   = 1'b0;
                  bst_d   = burst_done ? B_GAP : B_OFF;
                end else begin
                  phase_d = phase_q + 1'b1;
                end
              end
              B_OFF: begin
                if (ph_end) begin
                  phase_d = '0;
                  led_d   = 1'b1;
                  bst_d   = B_ON;
                end else begin
                  phase_d = phase_q + 1'b1;
                end
              end
              B_GAP: begin
                if (gap_end) begin
                  phase_d = '0;
                  pulse_d = '0;
                  led_d   = 1'b1;
                  bst_d   = B_ON;
                end else begin
                  phase_d = phase_q + 1'b1;
                end
              end
              default: bst_d = B_ON;
            endcase
          end
          default: ;
        endcase
      end
    end

    always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
        mode_q  <= MODE_OFF;
        bst_q   <= B_ON;
        half_q  <= PERIOD_W'(1);
        num_q   <= BURST_W'(1);
        phase_q <= '0;
        pulse_q <= '0;
        led_q   <= 1'b0;
      end else begin
        mode_q  <= mode_d;
        bst_q   <= bst_d;
        half_q  <= half_d;
        num_q   <= num_d;
        phase_q <= phase_d;
        pulse_q <= pulse_d;
        led_q   <= led_d;
      end
    end

    assign led[i] = led_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_led_pattern_blinker.sv
`default_nettype none
// ============================================================================
// Module  : tb_multi_led_pattern_blinker
// Brief   : Directed bench for multi_led_pattern_blinker (DIV=10, 4 and 5 channels).
// Revision: 1.0
// ============================================================================
module tb_multi_led_pattern_blinker;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_valid5 = 1'b0;
  logic [2:0]  cfg_ch = '0;
  logic [1:0]  cfg_mode = '0;
  logic [11:0] cfg_half_period = '0;
  logic [2:0]  cfg_count = '0;

  logic        cfg_ready, cfg_err, base_tick;
  logic [3:0]  led;
  logic        cfg_ready5, cfg_err5, base_tick5;
  logic [4:0]  led5;

  int cyc = 0;
  int passes = 0;
  int fails = 0;
  int total = 0;

  multi_led_pattern_blinker #(
    .CLK_FREQ(20), .TICK_FREQ(2), .NUM_CH(4), .PERIOD_W(12), .BURST_W(3)
  ) u_dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch[1:0]), .cfg_mode(cfg_mode), .cfg_half_period(cfg_half_period),
    .cfg_count(cfg_count), .cfg_err(cfg_err), .base_tick(base_tick), .led(led)
  );

  // Five channels give cfg_ch a third bit so out-of-range writes are reachable.
  multi_led_pattern_blinker #(
    .CLK_FREQ(20), .TICK_FREQ(2), .NUM_CH(5), .PERIOD_W(12), .BURST_W(3)
  ) u_dut5 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .cfg_valid(cfg_valid5), .cfg_ready(cfg_ready5),
    .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_half_period(cfg_half_period),
    .cfg_count(cfg_count), .cfg_err(cfg_err5), .base_tick(base_tick5), .led(led5)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) begin
    if (sys_rst) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic goto(input int k);
    int guard = 0;
    while (cyc != k && guard < 2000) begin
      @(negedge sys_clk);
      guard++;
    end
    if (cyc != k) chk("goto_timeout", 32'(cyc), 32'(k));
  endtask

  task automatic wr(input bit to5, input int ch, input int mode, input int h, input int n);
    cfg_ch          = 3'(ch);
    cfg_mode        = 2'(mode);
    cfg_half_period = 12'(h);
    cfg_count       = 3'(n);
    if (to5) cfg_valid5 = 1'b1;
    else     cfg_valid  = 1'b1;
    @(negedge sys_clk);
    cfg_valid  = 1'b0;
    cfg_valid5 = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge sys_clk);
    chk("rst_led", 32'(led), 32'h0);
    chk("rst_tick", 32'(base_tick), 32'h0);
    chk("rst_err", 32'(cfg_err), 32'h0);
    chk("rst_ready", 32'(cfg_ready), 32'h0);
    sys_rst = 1'b0;

    goto(1);   chk("ready_c1", 32'(cfg_ready), 32'h1);
               chk("tick_c1", 32'(base_tick), 32'h0);
    goto(9);   chk("tick_c9", 32'(base_tick), 32'h0);
    goto(10);  chk("tick_c10", 32'(base_tick), 32'h1);
    goto(11);  chk("tick_c11", 32'(base_tick), 32'h0);
    goto(20);  chk("tick_c20", 32'(base_tick), 32'h1);

    // ch0 BLINK H=3
    goto(21);  wr(0, 0, 2, 3, 0);
    chk("blink_c22", 32'(led), 32'h1);
    goto(50);  chk("blink_c50", 32'(led), 32'h1);
    goto(51);  chk("blink_c51", 32'(led), 32'h0);

    // ch1 BURST H=1 N=3
    goto(54);  wr(0, 1, 3, 1, 3);
    chk("burst_c55", 32'(led), 32'h2);
    goto(60);  chk("burst_c60", 32'(led), 32'h2);
    goto(61);  chk("burst_c61", 32'(led), 32'h0);
    goto(71);  chk("burst_c71", 32'(led), 32'h2);
    goto(81);  chk("burst_c81", 32'(led), 32'h1);
    goto(91);  chk("burst_c91", 32'(led), 32'h3);
    goto(101); chk("burst_c101", 32'(led), 32'h1);
    goto(140); chk("gap_c140", 32'(led), 32'h0);
    goto(141); chk("gap_c141", 32'(led), 32'h3);
    goto(151); chk("burst_c151", 32'(led), 32'h1);

    // ch2 ON, OFF with H=0, then BLINK with H=0 (acts as H=1)
    goto(155); wr(0, 2, 1, 0, 0);
    chk("on_c156", 32'(led), 32'h5);
    wr(0, 2, 0, 0, 0);
    chk("off_c157", 32'(led), 32'h1);
    wr(0, 2, 2, 0, 0);
    chk("h0_c158", 32'(led), 32'h5);
    chk("err_valid_ch", 32'(cfg_err), 32'h0);
    goto(160); chk("h0_c160", 32'(led), 32'h5);
    goto(161); chk("h0_c161", 32'(led), 32'h3);
    goto(171); chk("h0_c171", 32'(led), 32'h4);

    // ch0 rewrite in the tick cycle: the write wins, phase restarts at 0
    goto(180); chk("coll_tick", 32'(base_tick), 32'h1);
               chk("coll_c180", 32'(led), 32'h4);
    wr(0, 0, 2, 2, 0);
    chk("coll_c181", 32'(led), 32'h3);
    goto(191); chk("coll_c191", 32'(led), 32'h5);
    goto(201); chk("coll_c201", 32'(led), 32'h0);
    goto(235); chk("pre_rst_c235", 32'(led), 32'h7);

    // reset mid-burst
    sys_rst = 1'b1;
    @(negedge sys_clk);
    chk("mid_rst_led", 32'(led), 32'h0);
    chk("mid_rst_ready", 32'(cfg_ready), 32'h0);
    chk("mid_rst_tick", 32'(base_tick), 32'h0);
    sys_rst = 1'b0;
    goto(1);   chk("post_rst_ready", 32'(cfg_ready), 32'h1);
               chk("post_rst_led", 32'(led), 32'h0);
    goto(10);  chk("post_rst_tick", 32'(base_tick), 32'h1);
    goto(11);  chk("post_rst_c11", 32'(led), 32'h0);
    goto(41);  chk("post_rst_c41", 32'(led), 32'h0);

    // ch1 BURST H=1 N=0 (acts as N=1): one pulse then 4-tick gap
    wr(0, 1, 3, 1, 0);
    chk("n0_c42", 32'(led), 32'h2);
    goto(50);  chk("n0_c50", 32'(led), 32'h2);
    goto(51);  chk("n0_c51", 32'(led), 32'h0);
    goto(61);  chk("n0_c61", 32'(led), 32'h0);
    goto(90);  chk("n0_c90", 32'(led), 32'h0);
    goto(91);  chk("n0_c91", 32'(led), 32'h2);

    // out-of-range channel on the 5-channel instance
    goto(95);  wr(1, 0, 1, 1, 1);
    chk("e5_c96_led", 32'(led5), 32'h01);
    chk("e5_c96_err", 32'(cfg_err5), 32'h0);
    wr(1, 5, 1, 1, 1);
    chk("e5_c97_err", 32'(cfg_err5), 32'h1);
    chk("e5_c97_led", 32'(led5), 32'h01);
    chk("e4_c97_main_err", 32'(cfg_err), 32'h0);
    wr(1, 4, 1, 1, 1);
    chk("e5_c98_err", 32'(cfg_err5), 32'h0);
    chk("e5_c98_led", 32'(led5), 32'h11);
    wr(1, 7, 0, 1, 1);
    chk("e5_c99_err", 32'(cfg_err5), 32'h1);
    chk("e5_c99_led", 32'(led5), 32'h11);
    @(negedge sys_clk);
    chk("e5_c100_err", 32'(cfg_err5), 32'h0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
`default_nettype wire
